// File: rtl/axi_2_obi.sv
// AXI4 subordinate to OBI manager bridge.
// Bursts are split into single-beat OBI accesses, one outstanding at a time.

package axi_2_obi_pkg;
   localparam int unsigned IDW = 4;
   localparam int unsigned AW  = 32;
   localparam int unsigned DW  = 32;
   localparam int unsigned SW  = DW / 8;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [AW-1:0]  addr;
      logic [7:0]     len;
      logic [2:0]     size;
      logic [1:0]     burst;
   } axi_aw_t;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [AW-1:0]  addr;
      logic [7:0]     len;
      logic [2:0]     size;
      logic [1:0]     burst;
   } axi_ar_t;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [SW-1:0] strb;
      logic          last;
   } axi_w_t;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [1:0]     resp;
   } axi_b_t;

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [DW-1:0]  data;
      logic [1:0]     resp;
      logic           last;
   } axi_r_t;

   typedef struct packed {
      axi_aw_t aw;
      logic    aw_valid;
      axi_w_t  w;
      logic    w_valid;
      logic    b_ready;
      axi_ar_t ar;
      logic    ar_valid;
      logic    r_ready;
   } axi_req_bus_t;

   typedef struct packed {
      logic   aw_ready;
      logic   ar_ready;
      logic   w_ready;
      logic   b_valid;
      axi_b_t b;
      logic   r_valid;
      axi_r_t r;
   } axi_resp_bus_t;
endpackage

module axi_2_obi #(
   parameter int unsigned OBI_ADDRW = 32,
   parameter int unsigned OBI_DATAW = 32,
   parameter int unsigned OBI_STRBW = OBI_DATAW / 8,
   parameter type aw_chan_t  = axi_2_obi_pkg::axi_aw_t,
   parameter type ar_chan_t  = axi_2_obi_pkg::axi_ar_t,
   parameter type w_chan_t   = axi_2_obi_pkg::axi_w_t,
   parameter type r_chan_t   = axi_2_obi_pkg::axi_r_t,
   parameter type b_chan_t   = axi_2_obi_pkg::axi_b_t,
   parameter type axi_req_t  = axi_2_obi_pkg::axi_req_bus_t,
   parameter type axi_resp_t = axi_2_obi_pkg::axi_resp_bus_t
) (
   input  logic                 clk_i,
   input  logic                 srst_i,
   input  axi_req_t             axi_req_i,
   output axi_resp_t            axi_resp_o,
   output logic                 req_o,
   input  logic                 gnt_i,
   output logic [OBI_ADDRW-1:0] addr_o,
   output logic                 we_o,
   output logic [OBI_STRBW-1:0] be_o,
   output logic [OBI_DATAW-1:0] wdata_o,
   input  logic                 rvalid_i,
   input  logic [OBI_DATAW-1:0] rdata_i
);
   import axi_2_obi_pkg::*;

   typedef enum logic [3:0] {
      IDLE, RD_REQ, RD_WAIT, RD_RESP,
      WR_DATA, WR_REQ, WR_WAIT, WR_RESP, WR_DRAIN
   } state_t;

   state_t state, state_nx;

   aw_chan_t aw;
   ar_chan_t ar;
   w_chan_t  w;
   r_chan_t  r;
   b_chan_t  b;

   logic [IDW-1:0]       id_q;
   logic [OBI_ADDRW-1:0] addr_q, addr_nx;
   logic [7:0]           len_q, cnt_q;
   logic [2:0]           size_q;
   logic [1:0]           burst_q;
   logic                 err_q, last_wr_q, we_q;
   logic [OBI_DATAW-1:0] rdata_q, wdata_q;
   logic [OBI_STRBW-1:0] be_q;
   logic                 sel_rd, ar_hs, aw_hs, last_beat, live;

   assign aw = axi_req_i.aw;
   assign ar = axi_req_i.ar;
   assign w  = axi_req_i.w;

   assign live   = ~srst_i;
   // Read wins a tie only when the previous transaction was a write.
   assign sel_rd = axi_req_i.ar_valid & (~axi_req_i.aw_valid | last_wr_q);
   assign ar_hs  = (state == IDLE) & live & sel_rd;
   assign aw_hs  = (state == IDLE) & live & axi_req_i.aw_valid & ~sel_rd;

   assign last_beat = (cnt_q == len_q);
   assign addr_nx   = (burst_q == BURST_INCR) ?
                      addr_q + (OBI_ADDRW'(1) << size_q) : addr_q;

   assign addr_o  = addr_q;
   assign we_o    = we_q;
   assign be_o    = be_q;
   assign wdata_o = wdata_q;

   always_ff @(posedge clk_i) begin
      if (srst_i) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (ar_hs)
               state_nx = (ar.burst == BURST_WRAP) ? RD_RESP : RD_REQ;
            else if (aw_hs)
               state_nx = (aw.burst == BURST_WRAP) ? WR_DRAIN : WR_DATA;
         end
         RD_REQ:   if (gnt_i) state_nx = RD_WAIT;
         RD_WAIT:  if (rvalid_i) state_nx = RD_RESP;
         RD_RESP: begin
            if (axi_req_i.r_ready)
               state_nx = last_beat ? IDLE : (err_q ? RD_RESP : RD_REQ);
         end
         WR_DATA:  if (axi_req_i.w_valid) state_nx = WR_REQ;
         WR_REQ:   if (gnt_i) state_nx = WR_WAIT;
         WR_WAIT:  if (rvalid_i) state_nx = last_beat ? WR_RESP : WR_DATA;
         WR_DRAIN: if (axi_req_i.w_valid & last_beat) state_nx = WR_RESP;
         WR_RESP:  if (axi_req_i.b_ready) state_nx = IDLE;
         default:  state_nx = IDLE;
      endcase
   end

   always_comb begin
      r        = '0;
      r.id     = id_q;
      r.data   = rdata_q;
      r.resp   = err_q ? RESP_SLVERR : RESP_OKAY;
      r.last   = last_beat;
      b        = '0;
      b.id     = id_q;
      b.resp   = err_q ? RESP_SLVERR : RESP_OKAY;
      req_o    = live & ((state == RD_REQ) | (state == WR_REQ));
      axi_resp_o          = '0;
      axi_resp_o.ar_ready = ar_hs;
      axi_resp_o.aw_ready = aw_hs;
      axi_resp_o.w_ready  = live & ((state == WR_DATA) | (state == WR_DRAIN));
      axi_resp_o.r_valid  = live & (state == RD_RESP);
      axi_resp_o.b_valid  = live & (state == WR_RESP);
      axi_resp_o.r        = r;
      axi_resp_o.b        = b;
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         id_q      <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         size_q    <= '0;
         burst_q   <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         last_wr_q <= 1'b1;
         rdata_q   <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         we_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (ar_hs) begin
                  id_q    <= ar.id;
                  addr_q  <= ar.addr;
                  len_q   <= ar.len;
                  size_q  <= ar.size;
                  burst_q <= ar.burst;
                  cnt_q   <= '0;
                  err_q   <= (ar.burst == BURST_WRAP);
                  rdata_q <= '0;
                  be_q    <= '1;
                  we_q    <= 1'b0;
               end else if (aw_hs) begin
                  id_q    <= aw.id;
                  addr_q  <= aw.addr;
                  len_q   <= aw.len;
                  size_q  <= aw.size;
                  burst_q <= aw.burst;
                  cnt_q   <= '0;
                  err_q   <= (aw.burst == BURST_WRAP);
                  we_q    <= 1'b1;
               end
            end
            RD_WAIT: if (rvalid_i) rdata_q <= rdata_i;
            RD_RESP: begin
               if (axi_req_i.r_ready) begin
                  if (last_beat) begin
                     last_wr_q <= 1'b0;
                  end else begin
                     cnt_q  <= cnt_q + 8'd1;
                     addr_q <= addr_nx;
                  end
               end
            end
            WR_DATA: begin
               if (axi_req_i.w_valid) begin
                  wdata_q <= w.data;
                  be_q    <= w.strb;
                  if (w.last != last_beat) err_q <= 1'b1;
               end
            end
            WR_WAIT: begin
               if (rvalid_i & ~last_beat) begin
                  cnt_q  <= cnt_q + 8'd1;
                  addr_q <= addr_nx;
               end
            end
            WR_DRAIN: begin
               if (axi_req_i.w_valid & ~last_beat) cnt_q <= cnt_q + 8'd1;
            end
            WR_RESP: if (axi_req_i.b_ready) last_wr_q <= 1'b1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_2_obi.sv
// Bench for axi_2_obi: random AXI bursts against a transaction-level model.
// A behavioural OBI memory answers with random grant/response delays.

module tb_axi_2_obi;
   import axi_2_obi_pkg::*;

   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
   } obi_acc_t;

   logic clk_i = 1'b0;
   logic srst_i;
   axi_req_bus_t  axi_req;
   axi_resp_bus_t axi_resp;
   logic        req_o, gnt_i, we_o, rvalid_i;
   logic [31:0] addr_o, wdata_o, rdata_i;
   logic [3:0]  be_o;

   logic    aw_valid, w_valid, b_ready, ar_valid, r_ready;
   axi_aw_t aw;
   axi_w_t  w;
   axi_ar_t ar;

   always_comb begin
      axi_req          = '0;
      axi_req.aw       = aw;
      axi_req.aw_valid = aw_valid;
      axi_req.w        = w;
      axi_req.w_valid  = w_valid;
      axi_req.b_ready  = b_ready;
      axi_req.ar       = ar;
      axi_req.ar_valid = ar_valid;
      axi_req.r_ready  = r_ready;
   end

   always #5 clk_i = ~clk_i;

   axi_2_obi dut (
      .clk_i      (clk_i),
      .srst_i     (srst_i),
      .axi_req_i  (axi_req),
      .axi_resp_o (axi_resp),
      .req_o      (req_o),
      .gnt_i      (gnt_i),
      .addr_o     (addr_o),
      .we_o       (we_o),
      .be_o       (be_o),
      .wdata_o    (wdata_o),
      .rvalid_i   (rvalid_i),
      .rdata_i    (rdata_i)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   logic [31:0] ref_mem [bit [31:0]];
   logic [31:0] smem [bit [31:0]];
   obi_acc_t    exp_obi [$];
   obi_acc_t    obi_log [$];
   int          order_q [$];
   int          gnt_fix = -1;
   int          req_cycles = 0;
   bit          model_last_wr = 1'b1;

   logic [3:0]  rd_id, wr_id;
   logic [31:0] rd_addr, wr_addr;
   logic [7:0]  rd_len, wr_len;
   logic [2:0]  rd_size, wr_size;
   logic [1:0]  rd_burst, wr_burst;
   logic [31:0] wr_data [16];
   logic [3:0]  wr_strb [16];
   bit          wr_last [16];
   logic [31:0] rd_exp_data [16];
   logic [1:0]  rd_exp_resp, wr_exp_resp;

   function automatic logic [31:0] init_pat(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : init_pat(a);
   endfunction

   function automatic logic [31:0] s_rd(input logic [31:0] a);
      return smem.exists(a) ? smem[a] : init_pat(a);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] nw,
                                         input logic [3:0] st);
      logic [31:0] res;
      res = old;
      for (int k = 0; k < 4; k++)
         if (st[k]) res[8*k +: 8] = nw[8*k +: 8];
      return res;
   endfunction

   function automatic logic [31:0] baddr(input logic [31:0] a, input int i,
                                         input logic [2:0] sz,
                                         input logic [1:0] bu);
      return (bu == BURST_INCR) ? a + (32'(i) << sz) : a;
   endfunction

   // Reference: what each burst must do, beat by beat.
   function automatic void model_rd();
      logic [31:0] a;
      rd_exp_resp = (rd_burst == BURST_WRAP) ? RESP_SLVERR : RESP_OKAY;
      for (int i = 0; i <= int'(rd_len); i++) begin
         if (rd_burst == BURST_WRAP) begin
            rd_exp_data[i] = '0;
         end else begin
            a = baddr(rd_addr, i, rd_size, rd_burst);
            rd_exp_data[i] = ref_rd(a);
            exp_obi.push_back('{addr: a, we: 1'b0, be: 4'hF, wdata: 32'h0});
         end
      end
   endfunction

   function automatic void model_wr();
      logic [31:0] a;
      wr_exp_resp = (wr_burst == BURST_WRAP) ? RESP_SLVERR : RESP_OKAY;
      for (int i = 0; i <= int'(wr_len); i++) begin
         if (wr_last[i] != (i == int'(wr_len))) wr_exp_resp = RESP_SLVERR;
         if (wr_burst != BURST_WRAP) begin
            a = baddr(wr_addr, i, wr_size, wr_burst);
            exp_obi.push_back('{addr: a, we: 1'b1, be: wr_strb[i],
                                wdata: wr_data[i]});
            ref_mem[a] = merge(ref_rd(a), wr_data[i], wr_strb[i]);
         end
      end
   endfunction

   function automatic void set_rd(input logic [3:0] id, input logic [31:0] a,
                                  input logic [7:0] len, input logic [2:0] sz,
                                  input logic [1:0] bu);
      rd_id = id; rd_addr = a; rd_len = len; rd_size = sz; rd_burst = bu;
   endfunction

   function automatic void set_wr(input logic [3:0] id, input logic [31:0] a,
                                  input logic [7:0] len, input logic [2:0] sz,
                                  input logic [1:0] bu);
      wr_id = id; wr_addr = a; wr_len = len; wr_size = sz; wr_burst = bu;
      for (int i = 0; i < 16; i++) begin
         wr_data[i] = $urandom;
         wr_strb[i] = 4'($urandom_range(1, 15));
         wr_last[i] = (i == int'(len));
      end
   endfunction

   function automatic logic [1:0] rnd_burst();
      int r;
      r = $urandom_range(0, 7);
      if (r == 0) return BURST_WRAP;
      if (r < 3)  return BURST_FIXED;
      return BURST_INCR;
   endfunction

   // OBI memory with random grant and response latency.
   initial begin : obi_slave
      bit          pend, waiting;
      int          gdly, rdly;
      logic [31:0] pend_data;
      logic [36:0] held;
      gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0;
      pend = 1'b0; waiting = 1'b0; gdly = 0; rdly = 0;
      pend_data = '0; held = '0;
      forever begin
         @(posedge clk_i); #1;
         gnt_i = 1'b0; rvalid_i = 1'b0;
         if (srst_i) begin
            pend = 1'b0; waiting = 1'b0;
         end else begin
            if (req_o) req_cycles++;
            if (pend) begin
               if (rdly == 0) begin
                  rvalid_i = 1'b1; rdata_i = pend_data; pend = 1'b0;
               end else rdly--;
            end else if (req_o) begin
               if (!waiting) begin
                  waiting = 1'b1;
                  gdly = (gnt_fix >= 0) ? gnt_fix : $urandom_range(0, 3);
                  held = {we_o, be_o, addr_o};
               end else begin
                  chk("obi_addr_stable", {we_o, be_o, addr_o}, held);
               end
               if (gdly == 0) begin
                  gnt_i = 1'b1; waiting = 1'b0;
                  obi_log.push_back('{addr: addr_o, we: we_o, be: be_o,
                                      wdata: wdata_o});
                  if (we_o) begin
                     smem[addr_o] = merge(s_rd(addr_o), wdata_o, be_o);
                     pend_data = $urandom;
                  end else begin
                     pend_data = s_rd(addr_o);
                  end
                  pend = 1'b1;
                  rdly = $urandom_range(0, 2);
               end else gdly--;
            end
         end
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic sig(input int k);
      case (k)
         0: return axi_resp.ar_ready;
         1: return axi_resp.aw_ready;
         2: return axi_resp.w_ready;
         3: return axi_resp.r_valid;
         4: return axi_resp.b_valid;
         default: return 1'b0;
      endcase
   endfunction

   task automatic wait_hi(input int k, input string tag, output bit ok);
      int t;
      t = 0; ok = 1'b0;
      while (t < 2000) begin
         @(negedge clk_i);
         if (sig(k)) begin ok = 1'b1; break; end
         t++;
      end
      if (!ok) chk({tag, "_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic do_rd(input int hold);
      bit ok;
      int n;
      logic [31:0] d0;
      ar = '{id: rd_id, addr: rd_addr, len: rd_len, size: rd_size,
             burst: rd_burst};
      ar_valid = 1'b1;
      wait_hi(0, "ar", ok);
      @(posedge clk_i); #1;
      ar_valid = 1'b0;
      if (!ok) return;
      order_q.push_back(0);
      for (int i = 0; i <= int'(rd_len); i++) begin
         wait_hi(3, "r", ok);
         if (!ok) return;
         d0 = axi_resp.r.data;
         n = (hold < 0) ? $urandom_range(0, 2) : hold;
         repeat (n) begin
            @(negedge clk_i);
            chk("r_hold_valid", axi_resp.r_valid, 1);
            chk("r_hold_data", axi_resp.r.data, d0);
         end
         chk("r_id", axi_resp.r.id, rd_id);
         chk("r_data", axi_resp.r.data, rd_exp_data[i]);
         chk("r_resp", axi_resp.r.resp, rd_exp_resp);
         chk("r_last", axi_resp.r.last, (i == int'(rd_len)));
         r_ready = 1'b1;
         @(posedge clk_i); #1;
         r_ready = 1'b0;
      end
   endtask

   task automatic do_wr();
      bit ok;
      int n;
      aw = '{id: wr_id, addr: wr_addr, len: wr_len, size: wr_size,
             burst: wr_burst};
      aw_valid = 1'b1;
      wait_hi(1, "aw", ok);
      @(posedge clk_i); #1;
      aw_valid = 1'b0;
      if (!ok) return;
      order_q.push_back(1);
      for (int i = 0; i <= int'(wr_len); i++) begin
         n = $urandom_range(0, 1);
         repeat (n) begin @(posedge clk_i); #1; end
         w = '{data: wr_data[i], strb: wr_strb[i], last: wr_last[i]};
         w_valid = 1'b1;
         wait_hi(2, "w", ok);
         @(posedge clk_i); #1;
         w_valid = 1'b0;
         if (!ok) return;
      end
      wait_hi(4, "b", ok);
      if (!ok) return;
      chk("b_id", axi_resp.b.id, wr_id);
      chk("b_resp", axi_resp.b.resp, wr_exp_resp);
      b_ready = 1'b1;
      @(posedge clk_i); #1;
      b_ready = 1'b0;
   endtask

   task automatic check_obi();
      int m;
      chk("obi_count", obi_log.size(), exp_obi.size());
      m = (obi_log.size() < exp_obi.size()) ? obi_log.size() : exp_obi.size();
      for (int i = 0; i < m; i++) begin
         chk("obi_addr", obi_log[i].addr, exp_obi[i].addr);
         chk("obi_we", obi_log[i].we, exp_obi[i].we);
         chk("obi_be", obi_log[i].be, exp_obi[i].be);
         if (exp_obi[i].we) chk("obi_wdata", obi_log[i].wdata, exp_obi[i].wdata);
      end
      obi_log.delete();
      exp_obi.delete();
   endtask

   task automatic run_rd(input int hold);
      model_rd();
      model_last_wr = 1'b0;
      do_rd(hold);
      check_obi();
   endtask

   task automatic run_wr();
      model_wr();
      model_last_wr = 1'b1;
      do_wr();
      check_obi();
   endtask

   task automatic run_pair();
      bit first_rd;
      order_q.delete();
      first_rd = model_last_wr;
      if (first_rd) begin
         model_rd(); model_wr(); model_last_wr = 1'b1;
      end else begin
         model_wr(); model_rd(); model_last_wr = 1'b0;
      end
      fork
         do_rd(-1);
         do_wr();
      join
      chk("pair_first", (order_q.size() > 0) ? order_q[0] : 9,
          first_rd ? 0 : 1);
      check_obi();
   endtask

   initial begin : main
      int kind, snap;
      logic [31:0] a;
      aw = '0; w = '0; ar = '0;
      w_valid = 1'b0; b_ready = 1'b0; r_ready = 1'b0;
      aw_valid = 1'b1; ar_valid = 1'b1;
      srst_i = 1'b1;
      @(posedge clk_i);
      repeat (5) begin
         @(negedge clk_i);
         chk("reset_outs", {axi_resp.ar_ready, axi_resp.aw_ready,
             axi_resp.w_ready, axi_resp.r_valid, axi_resp.b_valid, req_o}, 0);
      end
      chk("reset_addr", addr_o, 0);
      chk("reset_obi", {we_o, be_o, wdata_o}, 0);
      aw_valid = 1'b0; ar_valid = 1'b0;
      @(posedge clk_i); #1;
      srst_i = 1'b0;
      @(posedge clk_i); #1;

      // First tie after reset goes to the read.
      set_rd(4'd1, 32'h2000, 8'd1, 3'd2, BURST_INCR);
      set_wr(4'd2, 32'h3000, 8'd1, 3'd2, BURST_INCR);
      run_pair();

      ref_mem[32'hAB] = 32'hDEADBEEF;
      smem[32'hAB]    = 32'hDEADBEEF;
      gnt_fix = 2;
      set_rd(4'd3, 32'hAB, 8'd0, 3'd2, BURST_INCR);
      run_rd(0);
      gnt_fix = -1;

      // Last served was a read, so this tie goes to the write.
      set_rd(4'd8, 32'h2100, 8'd2, 3'd2, BURST_INCR);
      set_wr(4'd9, 32'h3100, 8'd2, 3'd2, BURST_INCR);
      run_pair();

      set_wr(4'd5, 32'h100, 8'd3, 3'd2, BURST_INCR);
      for (int i = 0; i < 4; i++) wr_strb[i] = 4'hF;
      run_wr();

      set_rd(4'd6, 32'h200, 8'd1, 3'd2, BURST_FIXED);
      run_rd(4);

      set_wr(4'd7, 32'h300, 8'd1, 3'd2, BURST_INCR);
      wr_last[0] = 1'b1; wr_last[1] = 1'b0;
      run_wr();

      snap = req_cycles;
      set_rd(4'd10, 32'h400, 8'd1, 3'd2, BURST_WRAP);
      run_rd(1);
      chk("wrap_rd_no_req", req_cycles - snap, 0);

      set_wr(4'd11, 32'h500, 8'd2, 3'd2, BURST_WRAP);
      run_wr();

      set_rd(4'd12, 32'h100, 8'd3, 3'd2, BURST_INCR);
      run_rd(0);

      for (int t = 0; t < 40; t++) begin
         kind = $urandom_range(0, 2);
         a = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8
                                         : 32'h1000 + 32'($urandom_range(0, 63) << 2);
         if (kind == 0) begin
            set_rd(4'($urandom), a, 8'($urandom_range(0, 7)),
                   3'($urandom_range(0, 2)), rnd_burst());
            run_rd(-1);
         end else if (kind == 1) begin
            set_wr(4'($urandom), a, 8'($urandom_range(0, 7)),
                   3'($urandom_range(0, 2)), rnd_burst());
            for (int i = 0; i < 8; i++)
               if ($urandom_range(0, 7) == 0) wr_last[i] = ~wr_last[i];
            run_wr();
         end else begin
            set_rd(4'($urandom), 32'h5000 + 32'($urandom_range(0, 15) << 2),
                   8'($urandom_range(0, 7)), 3'($urandom_range(0, 2)),
                   rnd_burst());
            set_wr(4'($urandom), 32'h6000 + 32'($urandom_range(0, 15) << 2),
                   8'($urandom_range(0, 7)), 3'($urandom_range(0, 2)),
                   rnd_burst());
            run_pair();
         end
      end

      repeat (3) @(posedge clk_i);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/axi_2_obi.md
Name: axi_2_obi

Overview:
- AXI4 subordinate to OBI manager bridge: the reverse of obi_2_axi.
- Accepts AXI4 read and write bursts from an interconnect, then issues them as single-beat OBI transactions toward OBI-only peripherals and memories.
- Single clock domain, one outstanding OBI transaction at a time, no FIFOs.
- Placed between the SoC AXI crossbar and OBI slave subsystems.

Parameters:
- OBI_ADDRW, 32, OBI address width; equals the AXI addr width.
- OBI_DATAW, 32, OBI/AXI data width.
- OBI_STRBW, OBI_DATAW/8, byte-enable / wstrb width.
- aw_chan_t, ar_chan_t, w_chan_t, r_chan_t, b_chan_t, -, AXI channel struct types (axi/typedef.svh).
- axi_req_t, axi_resp_t, -, AXI request/response bundle types.

Ports:
- clk_i  input  1  clock
- srst_i  input  1  synchronous reset, active-high
- axi_req_i  input  axi_req_t  AXI request from the manager (aw/w/ar/b_ready/r_ready)
- axi_resp_o  output  axi_resp_t  AXI response to the manager (ready signals, b, r)
- req_o  output  1  OBI request
- gnt_i  input  1  OBI grant
- addr_o  output  OBI_ADDRW  OBI address
- we_o  output  1  OBI write enable
- be_o  output  OBI_STRBW  OBI byte enable
- wdata_o  output  OBI_DATAW  OBI write data
- rvalid_i  input  1  OBI response valid
- rdata_i  input  OBI_DATAW  OBI read data

Behaviour:
- Reset (srst_i=1 at a clk_i edge):
  - State goes to IDLE; all AXI ready/valid outputs go low; req_o=0; addr/wdata/be/we=0; beat counter=0; last-served flag=WRITE, so the first tie goes to the read.
  - Reset mid-transaction abandons everything, including a pending OBI grant. The OBI subordinate is reset by the same reset.
- States: IDLE, RD_REQ, RD_WAIT, RD_RESP, WR_DATA, WR_REQ, WR_WAIT, WR_RESP, WR_DRAIN.
- IDLE:
  - ar_ready = ar_valid & sel_rd; aw_ready = aw_valid & ~sel_rd; both combinational.
  - sel_rd = ar_valid & (~aw_valid | last_served==WRITE), i.e. alternation on a tie.
  - On handshake, latch id, addr, len, size, burst; beat counter=0.
  - Next state: read goes to RD_REQ; write with burst WRAP goes to WR_DRAIN; other writes go to WR_DATA.
- Read path:
  - RD_REQ: req_o=1, we_o=0, be_o='1, addr_o=current addr. OBI address-phase signals are held stable until gnt_i. On gnt_i go to RD_WAIT.
  - RD_WAIT: the earliest accepted rvalid_i is the cycle after the grant. On rvalid_i, register rdata_i and go to RD_RESP.
  - RD_RESP: r_valid=1, r.id=latched id, r.resp=OKAY, r.last=(cnt==len). On r_ready: if last, go to IDLE; else cnt++, addr += 2**size for INCR (unchanged for FIXED), go to RD_REQ.
  - AR with burst WRAP: no OBI access; return len+1 beats with data 0, resp SLVERR.
- Write path:
  - WR_DATA: w_ready=1. On w_valid, capture data/strb into wdata_o/be_o and go to WR_REQ.
  - WR_REQ: req_o=1, we_o=1. On gnt_i go to WR_WAIT.
  - WR_WAIT: on rvalid_i, if cnt==len go to WR_RESP; else cnt++, advance addr, go to WR_DATA.
  - Sticky error flag: set if w.last != (cnt==len) on any beat. The beat count from len governs regardless of w.last.
  - WR_DRAIN: w_ready=1, accept len+1 beats without OBI access, error flag set, then go to WR_RESP.
  - WR_RESP: b_valid=1, b.id=latched id, b.resp = error ? SLVERR : OKAY. On b_ready go to IDLE. On IDLE return, last_served is updated.
- Other rules:
  - Minimum OBI access per beat is 3 cycles (REQ with immediate grant, WAIT, then next state).
  - No 4 KB boundary checking; the address wraps modulo 2**OBI_ADDRW.
  - rvalid_i or gnt_i outside the REQ/WAIT states is ignored.

Test Plan:
- Reset check: hold srst_i=1 for 5 cycles with aw_valid=ar_valid=1 -> all readies, r_valid, b_valid and req_o stay 0 throughout reset.
- Single read: AR addr=0xAB, len=0, id=3; OBI grants after 2 cycles and returns rdata=0xDEADBEEF -> addr_o=0xAB stable until gnt_i; one R beat with data=0xDEADBEEF, id=3, last=1, resp=OKAY.
- INCR write burst: AW addr=0x100, len=3, size=2; 4 W beats with strb=0xF and w.last on beat 3 -> OBI writes to 0x100, 0x104, 0x108, 0x10C in order; B id matches AW, resp=OKAY.
- FIXED read burst: len=1, r_ready held low 4 cycles per beat -> both OBI reads to the same address; r_valid and r.data stay stable while r_ready=0.
- Simultaneous AW and AR after reset -> read served first, then the write. A second simultaneous pair is served write first.
- Error cases: write with w.last on beat 0 of len=1 -> B resp=SLVERR and both beats still written to OBI. AR with burst WRAP, len=1 -> 2 R beats with data 0, resp SLVERR, and req_o never asserted.
